// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the memory/writeback boundary: load size encodings
// and the MEM/WB pipeline register layout.
package writeback_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        reg_write;
        logic        memto_reg;
        logic        jump;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [31:0] pc;
    } mem_wb_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Extracts and extends a byte/half/word from an aligned memory word and flags
// accesses that cross their natural alignment.
module load_align
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_data,
    output logic [31:0] value,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        shifted = mem_data >> {offset, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = offset[1] ? mem_data[31:16] : mem_data[15:0];

        value      = 32'h0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  value = sext8(ld_byte);
            F3_LBU: value = {24'h0, ld_byte};
            F3_LH: begin
                misaligned = offset[0];
                value      = sext16(ld_half);
            end
            F3_LHU: begin
                misaligned = offset[0];
                value      = {16'h0, ld_half};
            end
            // LW and any unlisted encoding load the full word
            default: begin
                misaligned = (offset != 2'b00);
                value      = mem_data;
            end
        endcase

        if (misaligned) begin
            value = 32'h0;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback mux: one cycle from accept to
// register-file write, with a retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int COUNT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               in_RegWrite,
    input  logic               in_MemtoReg,
    input  logic               in_Jump,
    input  logic [4:0]         in_rd,
    input  logic [2:0]         in_funct3,
    input  logic [31:0]        in_alu_result,
    input  logic [31:0]        in_mem_data,
    input  logic [31:0]        in_pc,
    output logic               RegWrite,
    output logic [4:0]         write_id,
    output logic [31:0]        write_data,
    output logic               load_misaligned,
    output logic [COUNT_W-1:0] instret
);

    logic               accept;
    logic               wb_valid_d, wb_valid_q;
    mem_wb_t            wb_d, wb_q;
    logic [COUNT_W-1:0] instret_d, instret_q;
    logic [31:0]        load_value;
    logic               load_mis;

    assign accept = in_valid && !stall;

    always_comb begin
        wb_valid_d = accept;
        wb_d       = wb_q;
        instret_d  = instret_q;
        if (accept) begin
            wb_d.reg_write  = in_RegWrite;
            wb_d.memto_reg  = in_MemtoReg;
            wb_d.jump       = in_Jump;
            wb_d.rd         = in_rd;
            wb_d.funct3     = in_funct3;
            wb_d.alu_result = in_alu_result;
            wb_d.mem_data   = in_mem_data;
            wb_d.pc         = in_pc;
            instret_d       = instret_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            instret_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
            instret_q  <= instret_d;
        end
    end

    load_align u_load_align (
        .funct3     (wb_q.funct3),
        .offset     (wb_q.alu_result[1:0]),
        .mem_data   (wb_q.mem_data),
        .value      (load_value),
        .misaligned (load_mis)
    );

    // Outputs depend only on MEM/WB state, so nothing combinational reaches them from in_*
    always_comb begin
        RegWrite        = 1'b0;
        write_id        = 5'd0;
        write_data      = 32'h0;
        load_misaligned = 1'b0;
        if (wb_valid_q) begin
            RegWrite = wb_q.reg_write && (wb_q.rd != 5'd0);
            write_id = wb_q.rd;
            if (wb_q.jump) begin
                write_data = wb_q.pc + 32'd4;
            end else if (wb_q.memto_reg) begin
                write_data      = load_value;
                load_misaligned = load_mis;
            end else begin
                write_data = wb_q.alu_result;
            end
        end
    end

    assign instret = instret_q;

endmodule
